// File: rtl/id_ex_issue.sv
// Decode/issue stage: drives register file read addresses, captures the ID/EX register,
// bypasses same-edge writeback data and (with ID_LOAD_USE_INTERLOCK_EN) inserts load-use bubbles.
module id_ex_issue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_instr,
    input  logic [XLEN-1:0]   id_pc,
    output logic              id_ready,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              wb_reg_write,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [6:0]        ex_opcode,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic [XLEN-1:0] imm_decode(input logic [XLEN-1:0] ins);
        logic [XLEN-1:0] imm;
        imm = {XLEN{1'b0}};
        case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            OP_STORE:                 imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = XLEN'({ins[31:12], 12'h000});
            OP_JAL:                   imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                  imm = {XLEN{1'b0}};
        endcase
        return imm;
    endfunction

    logic [6:0]        w_opcode;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic              w_writer;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_hazard;
    logic              w_ready;
    logic              w_accept;

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic [XLEN-1:0]   r_ex_imm;
    logic [6:0]        r_ex_opcode;
    logic [2:0]        r_ex_funct3;
    logic [6:0]        r_ex_funct7;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic              r_ex_mem_write;
    logic              r_byp1;
    logic              r_byp2;
    logic [XLEN-1:0]   r_bdata1;
    logic [XLEN-1:0]   r_bdata2;

    assign w_opcode = id_instr[6:0];
    assign w_rs1    = id_instr[19:15];
    assign w_rs2    = id_instr[24:20];
    assign w_rd     = id_instr[11:7];
    assign rs1      = w_rs1;
    assign rs2      = w_rs2;

    // Control decode of the instruction sitting in ID
    always_comb begin
        w_writer    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        case (w_opcode)
            OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_writer = 1'b1;
            OP_LOAD: begin
                w_writer   = 1'b1;
                w_mem_read = 1'b1;
            end
            OP_STORE: w_mem_write = 1'b1;
            default: begin
                w_writer    = 1'b0;
                w_mem_read  = 1'b0;
                w_mem_write = 1'b0;
            end
        endcase
    end

`ifdef ID_LOAD_USE_INTERLOCK_EN
    logic w_uses_rs1;
    logic w_uses_rs2;

    // Which source registers the ID instruction actually reads
    always_comb begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC, OP_JAL:  w_uses_rs1 = 1'b0;
            OP_R, OP_STORE, OP_BRANCH: w_uses_rs2 = 1'b1;
            default: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b0;
            end
        endcase
    end

    assign w_hazard = id_valid && r_ex_valid && r_ex_mem_read && (r_ex_rd != {REG_AW{1'b0}}) &&
                      ((w_uses_rs1 && (r_ex_rd == w_rs1)) || (w_uses_rs2 && (r_ex_rd == w_rs2)));
`else
    assign w_hazard = 1'b0;
`endif

    // Flush wins over the interlock: the stalled instruction is dead anyway
    assign w_ready  = !w_hazard || flush;
    assign w_accept = id_valid && w_ready && !flush;
    assign id_ready = w_ready;

    // ID/EX pipeline register and writeback bypass capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= {XLEN{1'b0}};
            r_ex_rs1       <= {REG_AW{1'b0}};
            r_ex_rs2       <= {REG_AW{1'b0}};
            r_ex_rd        <= {REG_AW{1'b0}};
            r_ex_imm       <= {XLEN{1'b0}};
            r_ex_opcode    <= 7'd0;
            r_ex_funct3    <= 3'd0;
            r_ex_funct7    <= 7'd0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_byp1         <= 1'b0;
            r_byp2         <= 1'b0;
            r_bdata1       <= {XLEN{1'b0}};
            r_bdata2       <= {XLEN{1'b0}};
        end else begin
            r_ex_valid     <= w_accept;
            r_ex_pc        <= id_pc;
            r_ex_rs1       <= w_rs1;
            r_ex_rs2       <= w_rs2;
            r_ex_rd        <= w_rd;
            r_ex_imm       <= imm_decode(id_instr);
            r_ex_opcode    <= w_opcode;
            r_ex_funct3    <= id_instr[14:12];
            r_ex_funct7    <= id_instr[31:25];
            r_ex_reg_write <= w_writer && (w_rd != {REG_AW{1'b0}});
            r_ex_mem_read  <= w_mem_read;
            r_ex_mem_write <= w_mem_write;
            // The register file returns pre-write data on a same-edge read/write
            r_byp1         <= wb_reg_write && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == w_rs1);
            r_byp2         <= wb_reg_write && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == w_rs2);
            r_bdata1       <= wb_data;
            r_bdata2       <= wb_data;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_pc        = r_ex_pc;
    assign ex_rs1       = r_ex_rs1;
    assign ex_rs2       = r_ex_rs2;
    assign ex_rd        = r_ex_rd;
    assign ex_imm       = r_ex_imm;
    assign ex_opcode    = r_ex_opcode;
    assign ex_funct3    = r_ex_funct3;
    assign ex_funct7    = r_ex_funct7;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_mem_write = r_ex_mem_write;

    assign ex_rs1_data  = !r_ex_valid ? {XLEN{1'b0}} : (r_byp1 ? r_bdata1 : rf_rdata1);
    assign ex_rs2_data  = !r_ex_valid ? {XLEN{1'b0}} : (r_byp2 ? r_bdata2 : rf_rdata2);

endmodule

// File: tb/tb_id_ex_issue.sv
// Scoreboard bench for id_ex_issue: directed scenarios plus randomized traffic against
// an architectural model (register values, immediate arithmetic, load-use rule).
module tb_id_ex_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    id_ex_issue #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    // Register file environment: registered read, write-first is NOT provided
    logic [31:0] arch [32];
    logic        rf_init;
    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) arch[i] <= (i == 0) ? 32'h0 : (32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            arch[wb_rd] <= wb_data;
        end
        rf_rdata1 <= (rs1 == 5'd0) ? 32'h0 : arch[rs1];
        rf_rdata2 <= (rs2 == 5'd0) ? 32'h0 : arch[rs2];
    end

    typedef struct {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        rw, mr, mw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Architectural state of what sits in EX, used for the load-use rule
    logic       m_ex_valid = 1'b0;
    logic       m_ex_load  = 1'b0;
    logic [4:0] m_ex_rd    = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [31:0] s20, s19, s11;
        s20 = $signed(ins) >>> 20;
        s19 = $signed(ins) >>> 19;
        s11 = $signed(ins) >>> 11;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return s20;
            7'h23: return (s20 & ~32'h1f) | {27'h0, ins[11:7]};
            7'h63: return (s19 & 32'hFFFF_F000) | {20'h0, ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return (s11 & 32'hFFF0_0000) | {12'h0, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return arch[r];
    endfunction

    // Presents one ID cycle, predicts the EX result of the coming edge, returns at next posedge+2
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                        input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                        output logic stalled);
        exp_t e;
        logic [6:0] op;
        logic u1, u2, hz, rdy, acc;
        id_valid = v; id_instr = ins; id_pc = pc; flush = fl;
        wb_reg_write = wbw; wb_rd = wbrd; wb_data = wbd;
        op = ins[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
`ifdef ID_LOAD_USE_INTERLOCK_EN
        hz = v && m_ex_valid && m_ex_load && m_ex_rd != 5'd0 &&
             ((u1 && m_ex_rd == ins[19:15]) || (u2 && m_ex_rd == ins[24:20]));
`else
        hz = 1'b0;
`endif
        rdy = fl || !hz;
        acc = v && rdy && !fl;
        #1;
        chk("id_ready", {31'h0, id_ready}, {31'h0, rdy});
        e.v   = acc;
        e.pc  = pc;
        e.d1  = acc ? ref_operand(ins[19:15]) : 32'h0;
        e.d2  = acc ? ref_operand(ins[24:20]) : 32'h0;
        e.imm = ref_imm(ins);
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.op  = op; e.f3 = ins[14:12]; e.f7 = ins[31:25];
        e.rw  = (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 || op == 7'h17 ||
                 op == 7'h6F || op == 7'h67) && ins[11:7] != 5'd0;
        e.mr  = (op == 7'h03);
        e.mw  = (op == 7'h23);
        q.push_back(e);
        m_ex_valid = acc; m_ex_load = (op == 7'h03); m_ex_rd = ins[11:7];
        stalled = v && !rdy;
        @(posedge clk); #2;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", {31'h0, ex_valid}, {31'h0, e.v});
                chk("ex_rs1_data", ex_rs1_data, e.d1);
                chk("ex_rs2_data", ex_rs2_data, e.d2);
                if (e.v) begin
                    chk("ex_pc", ex_pc, e.pc);
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_regs", {17'h0, ex_rs1, ex_rs2, ex_rd}, {17'h0, e.rs1, e.rs2, e.rd});
                    chk("ex_fields", {15'h0, ex_funct7, ex_funct3, ex_opcode},
                                     {15'h0, e.f7, e.f3, e.op});
                    chk("ex_ctrl", {29'h0, ex_reg_write, ex_mem_read, ex_mem_write},
                                   {29'h0, e.rw, e.mr, e.mw});
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(9, 0)];
        ins[11:7]  = 5'($urandom_range(7, 0));
        ins[19:15] = 5'($urandom_range(7, 0));
        ins[24:20] = 5'($urandom_range(7, 0));
        return ins;
    endfunction

    initial begin
        logic        st;
        int          stalls;
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        rst_n = 1'b0; rf_init = 1'b0; id_valid = 1'b0; id_instr = 32'h0; id_pc = 32'h0;
        flush = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; wb_reg_write = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #2;
        rf_init = 1'b1;
        chk("reset_ex_valid", {31'h0, ex_valid}, 32'h0);
        chk("reset_rs1_data", ex_rs1_data, 32'h0);
        chk("reset_rs2_data", ex_rs2_data, 32'h0);
        chk("reset_ex_imm", ex_imm, 32'h0);
        chk("reset_ex_rd", {27'h0, ex_rd}, 32'h0);
        chk("reset_id_ready", {31'h0, id_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #2;

        step(1'b1, 32'h0070_0293, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, st);
        chk("addi_valid", {31'h0, ex_valid}, 32'h1);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_rd", {27'h0, ex_rd}, 32'h5);
        chk("addi_imm", ex_imm, 32'h7);
        chk("addi_reg_write", {31'h0, ex_reg_write}, 32'h1);
        chk("addi_rs1_data", ex_rs1_data, 32'h0);

        step(1'b1, 32'h0020_81B3, 32'h104, 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF, st);
        chk("bypass_rs1_data", ex_rs1_data, 32'hDEAD_BEEF);

        step(1'b1, 32'h0000_A203, 32'h108, 1'b0, 1'b0, 5'd0, 32'h0, st);
        stalls = 0;
        st = 1'b1;
        for (int i = 0; i < 4 && st; i++) begin
            step(1'b1, 32'h0042_0333, 32'h10C, 1'b0, 1'b0, 5'd0, 32'h0, st);
            if (st) stalls++;
        end
`ifdef ID_LOAD_USE_INTERLOCK_EN
        chk("load_use_stalls", 32'(stalls), 32'h1);
`else
        chk("load_use_stalls", 32'(stalls), 32'h0);
`endif
        chk("load_use_issue", {31'h0, ex_valid}, 32'h1);

        step(1'b1, 32'h0000_A203, 32'h110, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b1, 32'h0002_0063, 32'h114, 1'b1, 1'b0, 5'd0, 32'h0, st);
        chk("flush_bubble", {31'h0, ex_valid}, 32'h0);

        step(1'b1, 32'hFE20_AE23, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0, st);
        chk("sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("sw_ctrl", {30'h0, ex_mem_write, ex_reg_write}, 32'h2);
        step(1'b1, 32'h0010_00EF, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0, st);
        chk("jal_imm", ex_imm, 32'h0000_0800);
        step(1'b1, 32'hABCD_E3B7, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, st);
        chk("lui_imm", ex_imm, 32'hABCD_E000);

        step(1'b1, 32'h0020_81B3, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0, st);
        chk("pre_reset_valid", {31'h0, ex_valid}, 32'h1);
        rst_n = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("async_reset_valid", {31'h0, ex_valid}, 32'h0);
        chk("async_reset_rs1_data", ex_rs1_data, 32'h0);
        q.delete();
        m_ex_valid = 1'b0; m_ex_load = 1'b0; m_ex_rd = 5'd0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        st = 1'b0; v = 1'b0; ins = 32'h0; pc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            if (!st) begin
                v   = ($urandom_range(99, 0) < 85);
                ins = rand_instr();
                pc  = pc + 32'h4;
            end
            step(v, ins, pc, ($urandom_range(99, 0) < 10), 1'($urandom), 5'($urandom_range(7, 0)),
                 $urandom, st);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, st);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, st);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Decode/issue stage directly downstream of the register file. Drives the register file read addresses from the IF/ID instruction.
- Captures decoded fields into the ID/EX pipeline register on the same edge the register file registers its read data, so both arrive aligned at EX.
- Bypasses same-edge writeback data, which the register file does not return on a simultaneous read/write.
- Inserts load-use bubbles and honours branch flush.

Parameters:
XLEN, 32, datapath width of pc, instruction, operands, immediate
REG_AW, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  XLEN  IF/ID instruction; upstream holds it while id_ready=0
id_pc  in  XLEN  IF/ID pc
id_ready  out  1  0 = stall IF/ID (load-use hazard)
rs1  out  REG_AW  to register file, = id_instr[19:15], combinational
rs2  out  REG_AW  to register file, = id_instr[24:20], combinational
rf_rdata1  in  XLEN  register file read_data1 (registered, 1-cycle latency)
rf_rdata2  in  XLEN  register file read_data2
wb_rd  in  REG_AW  writeback destination (snooped)
wb_data  in  XLEN  writeback data (snooped)
wb_reg_write  in  1  writeback enable (snooped)
flush  in  1  kill the instruction in ID (taken branch/jump)
ex_valid  out  1  ID/EX holds a valid instruction
ex_pc  out  XLEN  pc
ex_rs1_data  out  XLEN  operand 1
ex_rs2_data  out  XLEN  operand 2
ex_rs1  out  REG_AW  source reg 1, for EX forwarding
ex_rs2  out  REG_AW  source reg 2, for EX forwarding
ex_rd  out  REG_AW  destination, id_instr[11:7]
ex_imm  out  XLEN  sign-extended immediate
ex_opcode  out  7  opcode
ex_funct3  out  3  funct3
ex_funct7  out  7  funct7
ex_reg_write  out  1  writes rd (R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR), forced 0 if rd=0
ex_mem_read  out  1  LOAD
ex_mem_write  out  1  STORE

Behaviour:
- Reset (rst_n=0, async): all ex_* registers 0, ex_valid=0, bypass flags 0. ex_rs*_data read 0 because operands are masked while ex_valid=0.
- Capture at a rising edge:
  - accept = id_valid && id_ready && !flush.
  - Fields are always loaded. ex_valid <= accept.
  - Latency ID->EX is 1 cycle. Throughput is 1 instruction/cycle with no hazard.
- Immediate by opcode:
  - I (0010011, 0000011, 1100111): sext[31:20].
  - S (0100011): sext{[31:25],[11:7]}.
  - B (1100011): sext{[31],[7],[30:25],[11:8],0}.
  - U (0110111, 0010111): {[31:12],12'b0}.
  - J (1101111): sext{[31],[19:12],[20],[30:21],0}.
  - Anything else: 0.
- Writeback bypass:
  - At each edge: byp1 <= wb_reg_write && wb_rd!=0 && wb_rd==rs1, and bdata1 <= wb_data. Same for byp2/rs2.
  - ex_rs1_data = !ex_valid ? 0 : byp1 ? bdata1 : rf_rdata1. Same for operand 2.
  - rs=0 never bypasses; the register file returns 0 for it.
- Load-use hazard:
  - uses_rs1 = opcode not in {LUI, AUIPC, JAL}. uses_rs2 = opcode in {R 0110011, STORE, BRANCH}.
  - hazard = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
  - On hazard: id_ready=0 and a bubble is loaded (ex_valid<=0).
  - The held instruction re-presents rs, so the register file re-reads next cycle. Hazard clears after one cycle because the load leaves ID/EX.
- Flush:
  - Overrides the hazard: id_ready=1 and ex_valid<=0.
  - Flush while EX holds a valid instruction does not clear EX; the kill applies only to what enters.
- id_valid=0: ex_valid<=0 and id_ready=1.
- Reset asserted mid-stream: ex_valid drops immediately (async), all pending state is discarded, no bubble tracking is retained.

Optional Feature:
- Macro: ID_LOAD_USE_INTERLOCK_EN.
- Defined: hazard detection as above.
- Undefined: hazard is constant 0, id_ready = 1 always, and no bubbles are inserted (software scheduling guarantees load-use spacing). All other behaviour is identical.

Test Plan:
- Reset, then ADDI x5,x0,7 (0x00700293) at pc 0x100 -> next cycle ex_valid=1, ex_pc=0x100, ex_rd=5, ex_imm=7, ex_reg_write=1, ex_rs1_data=0.
- Same-edge bypass: ID holds ADD x3,x1,x2 while WB writes x1=0xDEADBEEF -> ex_rs1_data=0xDEADBEEF, not the stale register file value.
- Load-use: LW x4,0(x1) then ADD x6,x4,x4 -> id_ready=0 for 1 cycle, one bubble (ex_valid=0). ADD issues the following cycle. Without the macro, there is no stall.
- Flush: assert flush with BEQ in ID during a load-use hazard -> id_ready=1, next ex_valid=0.
- Immediate decode: SW x2,-4(x1) -> ex_imm=0xFFFFFFFC, ex_mem_write=1, ex_reg_write=0. JAL x1,+2048 -> ex_imm=0x00000800. LUI x7,0xABCDE -> ex_imm=0xABCDE000.
- Async reset mid-stream with ex_valid=1 -> ex_valid=0 and ex_rs1_data=0 before the next clock edge.
